// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - UART byte command sequencer for an 8x8 config register file
// Optional WAIT_DATA abort timer enabled by UART_CMD_TIMEOUT_EN.
module uart_cmd_sequencer #(
  parameter logic [3:0]  CMD_TAG        = 4'hA,
  parameter logic [63:0] REG_RESET      = 64'h0,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_data_valid,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_data_valid,
  output logic [63:0] o_regs,
  output logic [7:0]  o_wr_strobe,
  output logic        o_cmd_error,
  output logic        o_rx_overrun
);

  typedef enum logic [2:0] {IDLE, DECODE, WAIT_DATA, WAIT_TX, SEND} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cmd;
  logic [63:0] regs_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  wr_strobe_q;
  logic        overrun_q;
  logic        tmo_err_q;
  logic        timeout_hit;
  logic [2:0]  addr;
  logic        tag_ok;

  assign addr   = cmd[3:1];
  assign tag_ok = (cmd[7:4] == CMD_TAG);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  assign timeout_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == DECODE)
        tmo_cnt <= '0;
      else if (state == WAIT_DATA)
        tmo_cnt <= tmo_cnt + 1'b1;
      // an arriving byte in the final cycle wins over the abort
      tmo_err_q <= (state == WAIT_DATA) && !i_rx_data_valid && timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign tmo_err_q   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (i_rx_data_valid) state_nxt = DECODE;
      DECODE: begin
        if (!tag_ok)     state_nxt = IDLE;
        else if (cmd[0]) state_nxt = WAIT_DATA;
        else             state_nxt = WAIT_TX;
      end
      WAIT_DATA: if (i_rx_data_valid || timeout_hit) state_nxt = IDLE;
      WAIT_TX:   if (!i_tx_busy) state_nxt = SEND;
      SEND:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= IDLE;
      cmd         <= 8'h00;
      regs_q      <= REG_RESET;
      tx_data_q   <= 8'h00;
      wr_strobe_q <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_strobe_q <= 8'h00;
      overrun_q   <= i_rx_data_valid &&
                     (state == DECODE || state == WAIT_TX || state == SEND);
      if (state == IDLE && i_rx_data_valid)
        cmd <= i_rx_data;
      // read data is captured at DECODE so it reflects the register at that moment
      if (state == DECODE && tag_ok && !cmd[0])
        tx_data_q <= regs_q[{addr, 3'b000} +: 8];
      if (state == WAIT_DATA && i_rx_data_valid) begin
        regs_q[{addr, 3'b000} +: 8] <= i_rx_data;
        wr_strobe_q                 <= 8'b1 << addr;
      end
    end
  end

  assign o_tx_data       = tx_data_q;
  assign o_tx_data_valid = (state == SEND);
  assign o_regs          = regs_q;
  assign o_wr_strobe     = wr_strobe_q;
  assign o_cmd_error     = ((state == DECODE) && !tag_ok) || tmo_err_q;
  assign o_rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - self-checking bench for uart_cmd_sequencer
// Timeout steps run only when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_sequencer;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 100000;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [63:0] regs;
  logic [7:0]  wr_strobe;
  logic        cmd_error;
  logic        rx_overrun;

  int          tests = 0;
  int          fails = 0;
  int          tx_count = 0;
  logic [7:0]  model [8];
  logic [7:0]  exp_q [$];

  uart_cmd_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk           (clk),
    .i_nrst          (nrst),
    .i_rx_data       (rx_data),
    .i_rx_data_valid (rx_valid),
    .i_tx_busy       (tx_busy),
    .o_tx_data       (tx_data),
    .o_tx_data_valid (tx_valid),
    .o_regs          (regs),
    .o_wr_strobe     (wr_strobe),
    .o_cmd_error     (cmd_error),
    .o_rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = model[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic do_read(input logic [2:0] a);
    exp_q.push_back(model[a]);
    send_byte({4'hA, a, 1'b0});
    chk("rd_decode_valid", tx_valid, 1'b0);
    tick();
    chk("rd_waittx_valid", tx_valid, 1'b0);
    tick();
    chk("rd_send_valid", tx_valid, 1'b1);
    tick();
    chk("rd_after_valid", tx_valid, 1'b0);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    send_byte({4'hA, a, 1'b1});
    tick();
    send_byte(d);
    model[a] = d;
    chk("wr_strobe", wr_strobe, 8'b1 << a);
    chk("wr_regs", regs, model_flat());
    tick();
    chk("wr_strobe_clear", wr_strobe, 8'h00);
  endtask

  // transmit scoreboard: every strobe must match the oldest outstanding read
  always @(negedge clk) begin
    if (tx_valid) begin
      tx_count++;
      chk("tx_expected_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
    end
  end

  initial begin
    int saved;
    logic seen;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;

    repeat (3) tick();
    chk("rst_regs", regs, 64'h0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 8'h00);
    chk("rst_cmd_error", cmd_error, 1'b0);
    chk("rst_overrun", rx_overrun, 1'b0);
    nrst = 1'b1;
    tick();

    do_read(3'd2);

    do_write(3'd3, 8'h5C);
    chk("wr_reg3", regs[31:24], 8'h5C);
    do_read(3'd3);

    // bad tag
    send_byte(8'h34);
    chk("badtag_err", cmd_error, 1'b1);
    tick();
    chk("badtag_err_clear", cmd_error, 1'b0);
    chk("badtag_regs", regs, model_flat());
    chk("badtag_tx_valid", tx_valid, 1'b0);
    do_read(3'd0);

    // read while transmitter busy
    do_write(3'd7, 8'hC3);
    tx_busy = 1'b1;
    exp_q.push_back(model[7]);
    send_byte(8'hAE);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= tx_valid;
    end
    chk("busy_no_strobe", seen, 1'b0);
    tx_busy = 1'b0;
    tick();
    chk("busy_send_valid", tx_valid, 1'b1);
    chk("busy_send_data", tx_data, 8'hC3);
    tick();
    chk("busy_after_valid", tx_valid, 1'b0);

    // overrun during WAIT_TX
    do_write(3'd1, 8'h9A);
    exp_q.push_back(model[1]);
    send_byte(8'hA2);
    tick();
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("ovr_pulse", rx_overrun, 1'b1);
    chk("ovr_send_valid", tx_valid, 1'b1);
    chk("ovr_send_data", tx_data, 8'h9A);
    tick();
    chk("ovr_pulse_clear", rx_overrun, 1'b0);
    chk("ovr_regs", regs, model_flat());
    do_read(3'd1);

`ifdef UART_CMD_TIMEOUT_EN
    send_byte(8'hA3);
    tick();
    seen = 1'b0;
    repeat (TMO - 1) begin
      tick();
      seen |= cmd_error;
    end
    chk("tmo_no_early_err", seen, 1'b0);
    tick();
    chk("tmo_err", cmd_error, 1'b1);
    chk("tmo_no_write", wr_strobe, 8'h00);
    tick();
    chk("tmo_err_clear", cmd_error, 1'b0);
    chk("tmo_regs", regs, model_flat());
    do_read(3'd1);

    send_byte(8'hAB);
    tick();
    repeat (TMO - 1) tick();
    send_byte(8'h77);
    model[5] = 8'h77;
    chk("tmo_lastcycle_no_err", cmd_error, 1'b0);
    chk("tmo_lastcycle_strobe", wr_strobe, 8'h20);
    chk("tmo_lastcycle_regs", regs, model_flat());
    tick();
    chk("tmo_lastcycle_err_after", cmd_error, 1'b0);
`endif

    // reset in the middle of a write
    send_byte(8'hA9);
    tick();
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    nrst     = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    #1;
    chk("midwr_rst_regs", regs, 64'h0);
    chk("midwr_rst_tx_data", tx_data, 8'h00);
    chk("midwr_rst_cmd_error", cmd_error, 1'b0);
    tick();
    rx_valid = 1'b0;
    chk("midwr_rst_strobe", wr_strobe, 8'h00);
    chk("midwr_rst_regs_held", regs, 64'h0);
    nrst = 1'b1;
    tick();

    // reset with a read parked in WAIT_TX
    do_write(3'd2, 8'h42);
    tx_busy = 1'b1;
    send_byte(8'hA4);
    tick();
    tick();
    nrst = 1'b0;
    tx_busy = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    #1;
    chk("midrd_rst_regs", regs, 64'h0);
    chk("midrd_rst_tx_data", tx_data, 8'h00);
    saved = tx_count;
    tick();
    nrst = 1'b1;
    repeat (5) tick();
    chk("midrd_no_strobe", tx_count, saved);
    do_read(3'd2);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
